// File: rtl/code_lock_fsm.sv
// code_lock_fsm: BCD combination lock controller.
// Keypad strobes build a DIGITS-wide BCD entry. A submit compares it with the
// stored code. A match opens the lock for OPEN_SECS ticks. Repeated mismatches
// start a timed lockout. While open, setpw enters programming mode, and a
// submit in that mode stores the entry as the new code. Every output is taken
// straight from a register.
module code_lock_fsm #(
    parameter int                  DIGITS       = 4,
    parameter int                  TICK_DIV     = 50000000,
    parameter int                  OPEN_SECS    = 5,
    parameter int                  MAX_FAIL     = 3,
    parameter int                  LOCKOUT_SECS = 10,
    parameter logic [4*DIGITS-1:0] DEFAULT_CODE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIGITS-1:0]     inc,
    input  logic                  clr,
    input  logic                  submit,
    input  logic                  setpw,
    output logic [4*DIGITS-1:0]   entry,
    output logic                  unlocked,
    output logic                  locked_out,
    output logic [3:0]            countdown,
    output logic [3:0]            fail_cnt,
    output logic                  ok_pulse,
    output logic                  err_pulse
);

    localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [3:0]     OPEN_CNT  = 4'(OPEN_SECS);
    localparam logic [3:0]     LOCK_CNT  = 4'(LOCKOUT_SECS);
    localparam logic [3:0]     FAIL_MAX  = 4'(MAX_FAIL);

    typedef enum logic [1:0] {
        S_LOCKED  = 2'd0,
        S_OPEN    = 2'd1,
        S_PROG    = 2'd2,
        S_LOCKOUT = 2'd3
    } state_t;

    state_t                state_q;
    logic [4*DIGITS-1:0]   code_q;
    logic [4*DIGITS-1:0]   entry_q;
    logic [4*DIGITS-1:0]   entry_d;
    logic [PW-1:0]         presc_q;
    logic [3:0]            count_q;
    logic [3:0]            fail_q;
    logic                  unlocked_q;
    logic                  locked_out_q;
    logic                  ok_q;
    logic                  err_q;
    logic                  tick;

    // One BCD digit step: 9 wraps back to 0.
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    assign tick = (presc_q == PRESC_MAX);

    // Keypad edit of the entry: clr wins, otherwise every strobed digit steps.
    always_comb begin
        entry_d = entry_q;
        if (clr) begin
            entry_d = '0;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (inc[i]) begin
                    entry_d[4*i +: 4] = bcd_inc(entry_q[4*i +: 4]);
                end
            end
        end
    end

    // Lock state machine with prescaler, countdown, failure counter and outputs.
    // Every state change also restarts the prescaler, so a new state always
    // starts with a full tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_LOCKED;
            code_q       <= DEFAULT_CODE;
            entry_q      <= '0;
            presc_q      <= '0;
            count_q      <= 4'd0;
            fail_q       <= 4'd0;
            unlocked_q   <= 1'b0;
            locked_out_q <= 1'b0;
            ok_q         <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            presc_q <= tick ? '0 : presc_q + PW'(1);
            case (state_q)
                S_LOCKED: begin
                    if (submit) begin
                        // The check uses the entry as it stood before this cycle's keys.
                        entry_q <= '0;
                        if (entry_q == code_q) begin
                            state_q    <= S_OPEN;
                            presc_q    <= '0;
                            count_q    <= OPEN_CNT;
                            fail_q     <= 4'd0;
                            unlocked_q <= 1'b1;
                            ok_q       <= 1'b1;
                        end else begin
                            fail_q <= fail_q + 4'd1;
                            err_q  <= 1'b1;
                            if (fail_q + 4'd1 == FAIL_MAX) begin
                                state_q      <= S_LOCKOUT;
                                presc_q      <= '0;
                                count_q      <= LOCK_CNT;
                                locked_out_q <= 1'b1;
                            end
                        end
                    end else begin
                        entry_q <= entry_d;
                    end
                end
                S_OPEN, S_PROG: begin
                    // Priority: submit, then window expiry, then the setpw level.
                    if (submit || (tick && count_q == 4'd1)) begin
                        if (submit && state_q == S_PROG) begin
                            code_q <= entry_q;
                            ok_q   <= 1'b1;
                        end
                        state_q    <= S_LOCKED;
                        presc_q    <= '0;
                        count_q    <= 4'd0;
                        entry_q    <= '0;
                        unlocked_q <= 1'b0;
                    end else begin
                        entry_q <= entry_d;
                        if (tick) begin
                            count_q <= count_q - 4'd1;
                        end
                        if (state_q == S_OPEN && setpw) begin
                            state_q <= S_PROG;
                            presc_q <= '0;
                        end else if (state_q == S_PROG && !setpw) begin
                            state_q <= S_OPEN;
                            presc_q <= '0;
                        end
                    end
                end
                S_LOCKOUT: begin
                    // Keys and submit are ignored until the penalty ends.
                    if (tick) begin
                        if (count_q == 4'd1) begin
                            state_q      <= S_LOCKED;
                            presc_q      <= '0;
                            count_q      <= 4'd0;
                            fail_q       <= 4'd0;
                            entry_q      <= '0;
                            locked_out_q <= 1'b0;
                        end else begin
                            count_q <= count_q - 4'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_LOCKED;
                end
            endcase
        end
    end

    assign entry      = entry_q;
    assign unlocked   = unlocked_q;
    assign locked_out = locked_out_q;
    assign countdown  = count_q;
    assign fail_cnt   = fail_q;
    assign ok_pulse   = ok_q;
    assign err_pulse  = err_q;

endmodule

// File: tb/tb_code_lock_fsm.sv
// tb_code_lock_fsm: directed and randomized bench for code_lock_fsm.
// A behavioural model tracks the time left in the open or lockout window in
// clock cycles. It derives the displayed countdown by rounding that time up
// to whole ticks.
module tb_code_lock_fsm;

    localparam int              DIG  = 4;
    localparam int              TD   = 4;
    localparam int              OSEC = 3;
    localparam int              MF   = 3;
    localparam int              LSEC = 2;
    localparam logic [15:0]     DEF  = 16'h1234;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [DIG-1:0]  inc = '0;
    logic            clr = 1'b0;
    logic            submit = 1'b0;
    logic            setpw = 1'b0;
    logic [15:0]     entry;
    logic            unlocked, locked_out, ok_pulse, err_pulse;
    logic [3:0]      countdown, fail_cnt;

    logic            pw_lvl = 1'b0;
    bit              chk_on = 1'b0;
    int              n_cmp = 0;
    int              n_bad = 0;

    code_lock_fsm #(
        .DIGITS(DIG), .TICK_DIV(TD), .OPEN_SECS(OSEC), .MAX_FAIL(MF),
        .LOCKOUT_SECS(LSEC), .DEFAULT_CODE(DEF)
    ) dut (
        .clk(clk), .rst(rst), .inc(inc), .clr(clr), .submit(submit), .setpw(setpw),
        .entry(entry), .unlocked(unlocked), .locked_out(locked_out),
        .countdown(countdown), .fail_cnt(fail_cnt),
        .ok_pulse(ok_pulse), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_LOCKED, M_OPEN, M_PROG, M_LOCKOUT} mode_t;
    mode_t m_mode;
    int    m_ent  [DIG];
    int    m_code [DIG];
    int    m_remain;
    int    m_fail;
    bit    m_ok, m_err;

    function automatic logic [15:0] pack(input int d [DIG]);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < DIG; i++) v[4*i +: 4] = 4'(d[i]);
        return v;
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < DIG; i++) m_ent[i] = 0;
    endfunction

    function automatic void m_keys();
        if (clr) m_clear();
        else for (int i = 0; i < DIG; i++) if (inc[i]) m_ent[i] = (m_ent[i] + 1) % 10;
    endfunction

    function automatic void m_go_locked();
        m_mode   = M_LOCKED;
        m_remain = 0;
        m_clear();
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode = M_LOCKED; m_remain = 0; m_fail = 0; m_ok = 0; m_err = 0;
            m_clear();
            for (int i = 0; i < DIG; i++) m_code[i] = int'((DEF >> (4*i)) & 16'hF);
        end else begin
            m_ok = 0; m_err = 0;
            case (m_mode)
                M_LOCKED:
                    if (submit) begin
                        if (pack(m_ent) == pack(m_code)) begin
                            m_mode = M_OPEN; m_remain = OSEC * TD; m_fail = 0; m_ok = 1;
                        end else begin
                            m_fail++; m_err = 1;
                            if (m_fail == MF) begin
                                m_mode = M_LOCKOUT; m_remain = LSEC * TD;
                            end
                        end
                        m_clear();
                    end else m_keys();
                M_OPEN, M_PROG:
                    if (submit) begin
                        if (m_mode == M_PROG) begin m_code = m_ent; m_ok = 1; end
                        m_go_locked();
                    end else begin
                        m_remain--;
                        if (m_remain == 0) m_go_locked();
                        else begin
                            m_keys();
                            if ((m_mode == M_OPEN && setpw) || (m_mode == M_PROG && !setpw)) begin
                                m_mode   = (m_mode == M_OPEN) ? M_PROG : M_OPEN;
                                m_remain = ((m_remain + TD - 1) / TD) * TD;
                            end
                        end
                    end
                M_LOCKOUT: begin
                    m_remain--;
                    if (m_remain == 0) begin m_fail = 0; m_go_locked(); end
                end
                default: m_go_locked();
            endcase
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(posedge clk) begin
        #1;
        if (chk_on && rst) begin
            chk("entry",      32'(entry),      32'(pack(m_ent)));
            chk("unlocked",   32'(unlocked),   32'(m_mode == M_OPEN || m_mode == M_PROG));
            chk("locked_out", 32'(locked_out), 32'(m_mode == M_LOCKOUT));
            chk("countdown",  32'(countdown),  32'((m_remain + TD - 1) / TD));
            chk("fail_cnt",   32'(fail_cnt),   32'(m_fail));
            chk("ok_pulse",   32'(ok_pulse),   32'(m_ok));
            chk("err_pulse",  32'(err_pulse),  32'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [DIG-1:0] i_inc, input logic i_clr, input logic i_sub);
        @(negedge clk);
        inc = i_inc; clr = i_clr; submit = i_sub; setpw = pw_lvl;
        @(posedge clk);
        #1;
        inc = '0; clr = 1'b0; submit = 1'b0;
    endtask

    task automatic set_entry(input logic [15:0] v);
        drive('0, 1'b1, 1'b0);
        for (int j = 0; j < 9; j++) begin
            logic [DIG-1:0] b;
            b = '0;
            for (int i = 0; i < DIG; i++) if (int'(v[4*i +: 4]) > j) b[i] = 1'b1;
            drive(b, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int fall;
        logic [15:0] tgt;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        chk_on = 1'b1;
        #1;
        chk("reset entry", 32'(entry), 0);
        chk("reset unlocked", 32'(unlocked), 0);
        chk("reset countdown", 32'(countdown), 0);
        chk("reset fail_cnt", 32'(fail_cnt), 0);
        chk("reset locked_out", 32'(locked_out), 0);

        // Digit wrap and clr priority
        for (int k = 1; k <= 10; k++) begin
            drive(4'b0001, 1'b0, 1'b0);
            if (k == 9) chk("wrap entry after 9", 32'(entry), 32'h0009);
        end
        chk("wrap entry after 10", 32'(entry), 0);
        drive(4'b0010, 1'b1, 1'b0);
        chk("clr beats inc", 32'(entry), 0);

        // Unlock and timeout
        set_entry(16'h1234);
        chk("typed entry", 32'(entry), 32'h1234);
        drive('0, 1'b0, 1'b1);
        chk("unlock unlocked", 32'(unlocked), 1);
        chk("unlock countdown", 32'(countdown), 3);
        chk("unlock ok_pulse", 32'(ok_pulse), 1);
        fall = -1;
        for (int k = 1; k <= 20; k++) begin
            drive('0, 1'b0, 1'b0);
            if (k == 1) chk("ok one cycle", 32'(ok_pulse), 0);
            if (k == 4) chk("countdown 2", 32'(countdown), 2);
            if (k == 8) chk("countdown 1", 32'(countdown), 1);
            if (!unlocked && fall < 0) fall = k;
        end
        chk("open duration", 32'(fall), 12);

        // Lockout after three mismatches
        for (int n = 1; n <= 3; n++) begin
            drive('0, 1'b0, 1'b1);
            chk("fail count", 32'(fail_cnt), 32'(n));
            chk("mismatch err", 32'(err_pulse), 1);
        end
        chk("lockout flag", 32'(locked_out), 1);
        chk("lockout countdown", 32'(countdown), 2);
        for (int k = 1; k <= 8; k++) begin
            drive(4'hF, 1'b0, 1'b1);
            if (k < 8) chk("lockout held", 32'(locked_out), 1);
            if (k < 8) chk("lockout entry", 32'(entry), 0);
            if (k == 4) chk("lockout countdown 1", 32'(countdown), 1);
        end
        chk("lockout end", 32'(locked_out), 0);
        chk("lockout fail clear", 32'(fail_cnt), 0);

        // Program 9876
        set_entry(16'h1234);
        drive('0, 1'b0, 1'b1);
        pw_lvl = 1'b1;
        drive('0, 1'b0, 1'b0);
        set_entry(16'h9876);
        drive('0, 1'b0, 1'b1);
        chk("store ok", 32'(ok_pulse), 1);
        chk("store locked", 32'(unlocked), 0);
        pw_lvl = 1'b0;
        set_entry(16'h9876);
        drive('0, 1'b0, 1'b1);
        chk("new code unlocks", 32'(unlocked), 1);
        drive('0, 1'b0, 1'b1);
        chk("manual relock", 32'(unlocked), 0);
        chk("relock countdown", 32'(countdown), 0);
        set_entry(16'h1234);
        drive('0, 1'b0, 1'b1);
        chk("old code err", 32'(err_pulse), 1);

        // Programming abort on expiry
        set_entry(16'h9876);
        drive('0, 1'b0, 1'b1);
        pw_lvl = 1'b1;
        fall = -1;
        for (int k = 1; k <= 20; k++) begin
            drive('0, 1'b0, 1'b0);
            if (!unlocked && fall < 0) fall = k;
        end
        chk("prog window", 32'(fall), 13);
        pw_lvl = 1'b0;
        set_entry(16'h9876);
        drive('0, 1'b0, 1'b1);
        chk("code kept after abort", 32'(unlocked), 1);

        // Asynchronous reset while open
        drive('0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        #1;
        chk("async unlocked", 32'(unlocked), 0);
        chk("async entry", 32'(entry), 0);
        chk("async countdown", 32'(countdown), 0);
        rst = 1'b1;
        set_entry(16'h1234);
        drive('0, 1'b0, 1'b1);
        chk("default code restored", 32'(unlocked), 1);
        drive('0, 1'b0, 1'b1);

        // Randomized traffic against the model
        for (int it = 0; it < 150; it++) begin
            int n;
            if ($urandom_range(0, 2) == 0) begin
                tgt = pack(m_code);
            end else begin
                for (int i = 0; i < DIG; i++) tgt[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            pw_lvl = 1'($urandom_range(0, 3) == 0);
            set_entry(tgt);
            drive('0, 1'b0, 1'b1);
            n = $urandom_range(0, 20);
            for (int j = 0; j < n; j++) begin
                logic [DIG-1:0] ri;
                if ($urandom_range(0, 5) == 0) pw_lvl = ~pw_lvl;
                ri = ($urandom_range(0, 3) == 0) ? DIG'($urandom) : '0;
                drive(ri, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 9) == 0));
            end
        end

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/code_lock_fsm.md
Name: code_lock_fsm

Overview:
- Parametrised successor to the 4-digit combination lock controller; sits between debounced keypad/switch strobes and the display/LED drivers.
- Generalised to DIGITS BCD digits, with a configurable open window and an explicit submit strobe.
- Adds behaviour the previous generation lacks: failed-attempt counting with a timed lockout, manual relock, and password programming only while open, which aborts cleanly on timeout.

Parameters:
DIGITS, 4, number of BCD code digits (1..8)
TICK_DIV, 50000000, clk cycles per countdown tick (>=2)
OPEN_SECS, 5, ticks the lock stays open (1..15)
MAX_FAIL, 3, consecutive mismatches that trigger lockout (1..15)
LOCKOUT_SECS, 10, ticks of lockout (1..15)
DEFAULT_CODE, 16'h0000, reset code; nibble i = digit i; every nibble must be <=9

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
inc  in  DIGITS  one-cycle strobe per digit; increments entry digit i
clr  in  1  one-cycle strobe; clears all entry digits to 0
submit  in  1  one-cycle strobe; compare, store or relock, depending on state
setpw  in  1  level; requests programming mode
entry  out  4*DIGITS  current entry digits, digit i at [4i+3:4i]
unlocked  out  1  high in OPEN and PROG
locked_out  out  1  high in LOCKOUT
countdown  out  4  remaining ticks in OPEN/PROG/LOCKOUT; 0 in LOCKED
fail_cnt  out  4  consecutive mismatch count
ok_pulse  out  1  one-cycle pulse on successful unlock or code store
err_pulse  out  1  one-cycle pulse on mismatch

Behaviour:
- Reset (rst=0, async):
  - state=LOCKED; code=DEFAULT_CODE; entry=0; countdown=0; fail_cnt=0.
  - prescaler=0; all outputs low/zero.
- States: LOCKED, OPEN, PROG, LOCKOUT. All outputs are registered.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - Forced to 0 in the cycle any state transition occurs.
  - tick=1 when prescaler==TICK_DIV-1.
- Entry digits:
  - Each inc[i] adds 1 mod 10 (9 wraps to 0). Several bits in one cycle each apply.
  - clr has priority over inc in the same cycle.
  - inc and clr are ignored in LOCKOUT.
  - Entry is cleared on every submit that is acted on, and on every entry to LOCKED.
- LOCKED:
  - submit: compare the pre-update entry (ignoring same-cycle inc) against code.
  - Match: next state OPEN, countdown=OPEN_SECS, fail_cnt=0, ok_pulse=1.
  - Mismatch: fail_cnt+1, err_pulse=1.
    - If the new count == MAX_FAIL: next state LOCKOUT, countdown=LOCKOUT_SECS.
  - setpw is ignored in LOCKED.
- OPEN:
  - On tick: countdown-1. On the tick that takes 1 to 0, go to LOCKED.
  - Result: unlocked stays high for exactly OPEN_SECS*TICK_DIV cycles after an unlock.
  - submit with setpw=0: immediate relock to LOCKED, countdown=0.
  - setpw=1: go to PROG. countdown continues without reload.
- PROG:
  - submit: code<=entry, next state LOCKED, ok_pulse=1.
  - setpw=0 with no submit: return to OPEN, code unchanged.
  - Countdown expiry: go to LOCKED, code unchanged.
  - Simultaneous submit and expiry: the store wins.
- LOCKOUT:
  - submit is ignored.
  - Countdown decrements on tick. At 0: go to LOCKED, fail_cnt=0.
- Simultaneous events:
  - submit beats setpw changes.
  - clr/inc in the same cycle as an acted-on submit are discarded (entry clears).
- Widths:
  - Comparison is over all 4*DIGITS bits.
  - countdown and fail_cnt never exceed their parameter values.

Test Plan:
Common setup: DIGITS=4, TICK_DIV=4, OPEN_SECS=3, MAX_FAIL=3, LOCKOUT_SECS=2, DEFAULT_CODE=16'h1234.
- Reset mid-OPEN:
  - Stimulus: unlock, then pulse rst=0 for 1 ns between clocks.
  - Required: state LOCKED immediately; entry=0, code=1234, unlocked=0.
- Wrap and clr:
  - Stimulus: 10 inc[0] strobes, then inc[1]+clr in the same cycle.
  - Required: entry=0000 after the 10 strobes; entry=0000 after the clr cycle.
- Unlock and timeout:
  - Stimulus: set entry to 1234, then submit.
  - Required: next cycle unlocked=1, countdown=3, ok_pulse=1 for one cycle.
  - Required: countdown reads 2, then 1; unlocked falls exactly 12 cycles after rising.
- Lockout:
  - Stimulus: three submits with entry=0000.
  - Required: fail_cnt 1, 2, 3 with err_pulse each time; locked_out=1, countdown=2.
  - Required: inc and submit ignored for 8 cycles; then LOCKED with fail_cnt=0.
- Program:
  - Stimulus: unlock, setpw=1, enter 9876, submit; then relock and submit 9876.
  - Required: code updated, state LOCKED, ok_pulse; then the 9876 submit unlocks and 1234 gives err_pulse.
- Program abort and manual relock:
  - Stimulus A: in PROG, let the countdown expire.
  - Required A: LOCKED, code unchanged.
  - Stimulus B: in OPEN with setpw=0, submit.
  - Required B: unlocked=0 next cycle.
